seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the processor ALU.
//  - Keeps the existing ALUFN[5:0] encoding.
//  - Adds registered outputs, a valid/ready interface and an iterative shift-add multiplier.
//  - Adds a working SHR and an optional iterative unsigned divider.
//  - Sits between decode/operand-fetch and writeback; the multi-cycle stage is allowed to stall the pipeline.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/seq_alu_muldiv.sv | 87 ++++++++
 rtl/seq_alu.sv | 121 ++++++++++++
 tb/tb_seq_alu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and op classification for seq_alu.
// Optional divider is enabled with the SEQ_ALU_DIV_EN macro.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_SUB   = 6'h01;
  localparam logic [5:0] ALU_MUL   = 6'h02;
  localparam logic [5:0] ALU_DIV   = 6'h03;
  localparam logic [5:0] ALU_SHL   = 6'h20;
  localparam logic [5:0] ALU_SHR   = 6'h21;
  localparam logic [5:0] ALU_PASSA = 6'h22;
  localparam logic [5:0] ALU_SRA   = 6'h23;
  localparam logic [5:0] ALU_CMPEQ = 6'h33;
  localparam logic [5:0] ALU_CMPLT = 6'h35;
  localparam logic [5:0] ALU_CMPLE = 6'h37;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

  function automatic logic alu_is_multicycle(input logic [5:0] alufn);
`ifdef SEQ_ALU_DIV_EN
    return (alufn == ALU_MUL) || (alufn == ALU_DIV);
`else
    return alufn == ALU_MUL;
`endif
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider.
// One step per cycle for WIDTH cycles; res is the value the final step produces.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic             go;
  // acc: product / remainder, x: multiplicand / divisor, y: multiplier / dividend-quotient
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_n, x_n, y_n;

`ifdef SEQ_ALU_DIV_EN
  logic             mode_div;
  logic [WIDTH-1:0] rem_low;
  logic             fits;

  assign go  = start;
  assign dbz = mode_div && (x == '0);
  assign res = mode_div ? y_n : acc_n;
`else
  // No divider is built: a divide request never starts an iteration.
  assign go  = start && !op;
  assign dbz = 1'b0;
  assign res = acc_n;
`endif

  assign done = active && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    acc_n = acc + (y[0] ? x : '0);
    x_n   = x << 1;
    y_n   = y >> 1;
`ifdef SEQ_ALU_DIV_EN
    // Shifted remainder is {acc[MSB], rem_low}; the carried-out bit alone guarantees it fits.
    rem_low = {acc[WIDTH-2:0], y[WIDTH-1]};
    fits    = acc[WIDTH-1] || (rem_low >= x);
    if (mode_div) begin
      acc_n = fits ? (rem_low - x) : rem_low;
      x_n   = x;
      y_n   = {y[WIDTH-2:0], fits};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (go) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (go) begin
      acc <= '0;
      x   <= op ? b : a;
      y   <= op ? a : b;
`ifdef SEQ_ALU_DIV_EN
      mode_div <= op;
`endif
    end else if (active) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops registered in one cycle, MUL (and DIV when
// SEQ_ALU_DIV_EN is defined) iterate in seq_alu_muldiv for WIDTH+1 cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t state, state_n;
  logic accept, multi, md_done, md_dbz;
  logic [WIDTH-1:0] md_res;

  logic [WIDTH-1:0] bb, sum, sc_res;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0] sh;
  logic [3:0] tt;
  logic as_z, as_n, as_v, use_as, sc_z, sc_n, sc_v;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign multi     = alu_is_multicycle(alufn);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && multi),
    .op    (alufn == ALU_DIV),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res),
    .dbz   (md_dbz)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if ((state == IDLE) || out_ready) begin
          if (accept) state_n = multi ? ((alufn == ALU_DIV) ? DIV : MUL) : DONE;
          else        state_n = IDLE;
        end
      end
      MUL, DIV: if (md_done) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Add/sub path also serves the compares; alufn[0] is set for SUB and every CMP code.
  always_comb begin
    bb   = alufn[0] ? ~b : b;
    sum  = a + bb + {{(WIDTH-1){1'b0}}, alufn[0]};
    as_z = (sum == '0);
    as_n = sum[WIDTH-1];
    as_v = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    a_s  = a;
    sh   = b[SHW-1:0];
    tt   = alufn[3:0];
    sc_res = '0;
    use_as = 1'b0;
    casez (alufn)
      ALU_ADD, ALU_SUB: begin sc_res = sum; use_as = 1'b1; end
      6'b01????: for (int i = 0; i < WIDTH; i++) sc_res[i] = tt[{b[i], a[i]}];
      ALU_SHL:   sc_res = a << sh;
      ALU_SHR:   sc_res = a >> sh;
      ALU_PASSA: sc_res = a;
      ALU_SRA:   sc_res = a_s >>> sh;
      ALU_CMPEQ: begin sc_res = {{(WIDTH-1){1'b0}}, as_z}; use_as = 1'b1; end
      ALU_CMPLT: begin sc_res = {{(WIDTH-1){1'b0}}, as_n ^ as_v}; use_as = 1'b1; end
      ALU_CMPLE: begin sc_res = {{(WIDTH-1){1'b0}}, as_z | (as_n ^ as_v)}; use_as = 1'b1; end
      default: ;
    endcase
    sc_z = use_as ? as_z : (sc_res == '0);
    sc_n = use_as ? as_n : sc_res[WIDTH-1];
    sc_v = use_as && as_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu <= '0;
      z   <= 1'b0;
      v   <= 1'b0;
      n   <= 1'b0;
    end else if (accept && !multi) begin
      alu <= sc_res;
      z   <= sc_z;
      v   <= sc_v;
      n   <= sc_n;
    end else if (md_done) begin
      alu <= md_res;
      z   <= (md_res == '0);
      v   <= md_dbz;
      n   <= md_res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: requests push reference results, a monitor
// pops and compares whenever the ALU presents a result.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  alufn = 6'h00;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu;
  logic        z, v, n, busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;
  bit fixed_rdy = 1'b1;

  typedef struct {
    logic [31:0] res;
    logic        z, v, n;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .alu(alu), .z(z), .v(v), .n(n), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model written from the opcode rules with wide integer arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, s;
    logic [31:0] d;
    logic [63:0] p;
    logic [2:0] idx;
    bit flags_set;
    flags_set = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.z = 1'b0; e.v = 1'b0; e.n = 1'b0; e.lat = 1; e.acc = 0;
    if (f == ALU_ADD || f == ALU_SUB) begin
      s = (f == ALU_ADD) ? sx + sy : sx - sy;
      e.res = s[31:0];
      e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (f == ALU_CMPEQ || f == ALU_CMPLT || f == ALU_CMPLE) begin
      s = sx - sy;
      d = s[31:0];
      e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.z = (d == 32'h0);
      e.n = d[31];
      flags_set = 1'b1;
      if (f == ALU_CMPEQ)      e.res = {31'b0, x == y};
      else if (f == ALU_CMPLT) e.res = {31'b0, sx < sy};
      else                     e.res = {31'b0, sx <= sy};
    end else if (f[5:4] == 2'b01) begin
      for (int i = 0; i < 32; i++) begin
        idx = {1'b0, y[i], x[i]};
        e.res[i] = f[idx];
      end
    end else if (f == ALU_SHL) e.res = x << y[4:0];
    else if (f == ALU_SHR)     e.res = x >> y[4:0];
    else if (f == ALU_PASSA)   e.res = x;
    else if (f == ALU_SRA)     e.res = $signed(x) >>> y[4:0];
    else if (f == ALU_MUL) begin
      p = {32'b0, x} * {32'b0, y};
      e.res = p[31:0];
      e.lat = 33;
    end
`ifdef SEQ_ALU_DIV_EN
    else if (f == ALU_DIV) begin
      e.lat = 33;
      if (y == 0) begin e.res = 32'hFFFF_FFFF; e.v = 1'b1; end
      else e.res = x / y;
    end
`endif
    if (!flags_set) begin
      e.z = (e.res == 32'h0);
      e.n = e.res[31];
    end
    return e;
  endfunction

  task automatic monitor();
    bit fresh = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: alu %h presented with no request pending", alu);
        end else begin
          e = q[0];
          check("alu", alu, e.res);
          check("z", {31'b0, z}, {31'b0, e.z});
          check("v", {31'b0, v}, {31'b0, e.v});
          check("n", {31'b0, n}, {31'b0, e.n});
          if (fresh) check("latency", cyc - e.acc, e.lat - 1);
          fresh = 1'b0;
          check("in_ready_while_done", {31'b0, in_ready}, {31'b0, out_ready});
          if (out_ready) begin
            e = q.pop_front();
            fresh = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    exp_t e;
    alufn = f; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %h", f);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(f, x, y);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 13))
      0: return ALU_ADD;    1: return ALU_SUB;   2: return ALU_MUL;
      3: return ALU_DIV;    4: return ALU_SHL;   5: return ALU_SHR;
      6: return ALU_PASSA;  7: return ALU_SRA;   8: return ALU_CMPEQ;
      9: return ALU_CMPLT; 10: return ALU_CMPLE;
      11, 12: return {2'b01, 4'($urandom)};
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] x, y;
    fork
      monitor();
      drive_ready();
    join_none

    // Reset with a request pending.
    in_valid = 1'b1; alufn = ALU_ADD; a = 32'd1; b = 32'd1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_alu", alu, 32'h0);
    check("rst_flags", {28'b0, z, v, n, busy}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(ALU_CMPLT, 32'hFFFF_FFFF, 32'h0000_0001);
    drain();

    // Multiply with a competing request held during the iterations.
    issue(ALU_MUL, 32'h0001_0003, 32'h0000_0005);
    in_valid = 1'b1; alufn = ALU_ADD;
    for (int k = 0; k < 32; k++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      check("busy_during_mul", {31'b0, busy}, 32'h1);
      check("in_ready_during_mul", {31'b0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_after_mul", {31'b0, busy}, 32'h0);
    drain();

    issue(ALU_SHR, 32'h8000_0000, 32'd4);
    issue(ALU_SRA, 32'h8000_0000, 32'd4);
    drain();

    // Backpressure: result must hold while out_ready is low.
    fixed_rdy = 1'b0;
    @(posedge clk); #2;
    issue(ALU_SUB, 32'h8000_0000, 32'h0000_0001);
    repeat (5) begin
      @(negedge clk);
      check("in_ready_backpressure", {31'b0, in_ready}, 32'h0);
    end
    fixed_rdy = 1'b1;
    drain();

    issue(ALU_DIV, 32'd100, 32'd7);
    issue(ALU_DIV, 32'd5, 32'd0);
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Abort a running multiply with reset.
    alufn = ALU_MUL; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_abort", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_alu", alu, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (40) @(negedge clk);
    check("abort_no_output", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      x = pick();
      y = pick();
      if ($urandom_range(0, 7) == 0) y = x;
      issue(pick_op(), x, y);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    rand_rdy = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
